// File: rtl/timer_irq_ctrl.sv
// -----------------------------------------------------------------------------
// timer_irq_ctrl
//
// Interrupt controller between N_SRC timer-class peripherals and the CPU
// interrupt input. Incoming requests are latched into a pending register and
// gated by a CPU-programmable mask. Among the enabled requests, the one with
// the lowest index is granted. The grant is then held through an
// int_req / int_ack / EOI handshake.
//
// Parameters
//   N_SRC  number of interrupt sources (1..16)
//   ID_W   width of the source id (2**ID_W >= N_SRC)
//
// Ports
//   clk      in   system clock, all state changes on posedge
//   reset    in   asynchronous active-low reset
//   addr     in   [1:0]  register select (word address [3:2])
//   we       in   write enable for the register window
//   Din      in   [31:0] write data
//   Dout     out  [31:0] read data, combinational from addr
//   irq_in   in   [N_SRC-1:0] per-source requests
//   int_ack  in   CPU acknowledge of int_req (1-cycle pulse)
//   int_req  out  interrupt request to CPU
//   int_id   out  [ID_W-1:0] id of the granted source
//
// Register window
//   00 MASK     RW  [N_SRC-1:0], 1 = source enabled
//   01 PENDING  R / write-1-to-clear
//   10 INSVC    R   {busy[31], id[ID_W-1:0]}; reads 0 when not in service
//   11 EOI      W   any write ends service; reads 0
//
// Configuration
//   IRQ_EDGE_EN  when defined, pending[i] is set only by a rising edge of
//                irq_in[i]. When undefined, sources are level-sensitive.
// -----------------------------------------------------------------------------
module timer_irq_ctrl #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              int_ack,
  output logic              int_req,
  output logic [ID_W-1:0]   int_id
);

  localparam logic [1:0] ADDR_MASK  = 2'b00;
  localparam logic [1:0] ADDR_PEND  = 2'b01;
  localparam logic [1:0] ADDR_INSVC = 2'b10;
  localparam logic [1:0] ADDR_EOI   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_SVC  = 2'b10;

  logic [1:0]       state;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] set_req;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] clr_grant;
  logic [N_SRC-1:0] cand;
  logic [ID_W-1:0]  winner;
  logic             mask_wr;
  logic             eoi_wr;
  logic             grant_ack;
  logic             busy;

  // Bus decode.
  assign mask_wr   = we && (addr == ADDR_MASK);
  assign eoi_wr    = we && (addr == ADDR_EOI);
  assign w1c       = (we && (addr == ADDR_PEND)) ? Din[N_SRC-1:0] : '0;
  assign grant_ack = (state == ST_REQ) && int_ack;
  assign busy      = (state == ST_SVC);
  assign int_req   = (state == ST_REQ);

`ifdef IRQ_EDGE_EN
  // One registered copy of irq_in. A rising edge of irq_in sets pending.
  logic [N_SRC-1:0] irq_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_d <= '0;
    else        irq_d <= irq_in;
  end

  assign set_req = irq_in & ~irq_d;
`else
  // Level-sensitive: a request held high keeps pending set.
  assign set_req = irq_in;
`endif

  // Clear the granted source's pending bit on the acknowledge edge.
  always_comb begin
    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block leaves it unassigned (which would infer a latch).
    clr_grant = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr_grant[i] = grant_ack && (int_id == ID_W'(i));
    end
  end

  // Fixed priority: scan from high to low so the lowest set index wins.
  assign cand = pending & mask;

  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) winner = ID_W'(i);
    end
  end

  // Mask and pending registers. In the pending update, a set beats a clear in
  // the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask    <= '0;
      pending <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the values that were present before the edge.
      if (mask_wr) mask <= Din[N_SRC-1:0];
      pending <= (pending & ~w1c & ~clr_grant) | set_req;
    end
  end

  // Grant FSM. Once int_req is raised, the grant is committed. Masking the
  // source or clearing its pending bit does not withdraw the grant. A
  // higher-priority arrival never preempts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      int_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cand != '0) begin
            state  <= ST_REQ;
            int_id <= winner;
          end
        end
        ST_REQ: begin
          if (int_ack) state <= ST_SVC;
        end
        ST_SVC: begin
          if (eoi_wr) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read mux. Bits that are not used read as 0.
  always_comb begin
    Dout = '0;
    case (addr)
      ADDR_MASK:  Dout = {{(32 - N_SRC){1'b0}}, mask};
      ADDR_PEND:  Dout = {{(32 - N_SRC){1'b0}}, pending};
      ADDR_INSVC: Dout = busy ? {1'b1, {(31 - ID_W){1'b0}}, int_id} : '0;
      default:    Dout = '0;
    endcase
  end

endmodule
